iq_window_averager: RTL

//  Parametrised two-channel (I/Q) signed averager for the demodulator back-end; successor to the single-channel averager.

---
 rtl/iq_avg_pkg.sv | 19 +
 rtl/iq_delay_line.sv | 57 +++++
 rtl/iq_window_averager.sv | 135 +++++++++++++
 3 files changed

// File: rtl/iq_avg_pkg.sv
// Shared defaults, mode encoding and control-state constants for the I/Q window averager.
package iq_avg_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int LOG2_LEN_DEF = 3;

    localparam logic MODE_BLOCK = 1'b0;
    localparam logic MODE_SLIDE = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // Sum of 2^log2_len samples of data_w bits never overflows this width.
    function automatic int acc_w(input int data_w, input int log2_len);
        return data_w + log2_len;
    endfunction

endpackage

// File: rtl/iq_delay_line.sv
// N-deep circular buffer of paired I/Q samples; returns the oldest entry before it is overwritten.
module iq_delay_line
    import iq_avg_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOG2_LEN = LOG2_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_i,
    input  logic [DATA_W-1:0] wr_q,
    output logic [DATA_W-1:0] old_i,
    output logic [DATA_W-1:0] old_q,
    output logic              filled
);

    localparam int DEPTH = 1 << LOG2_LEN;
    localparam logic [LOG2_LEN-1:0] PTR_MAX = '1;

    logic [2*DATA_W-1:0]  mem_q [DEPTH];
    logic [LOG2_LEN-1:0]  wr_ptr_q, wr_ptr_d;
    logic                 filled_q, filled_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        filled_d = filled_q;
        if (clr) begin
            wr_ptr_d = '0;
            filled_d = 1'b0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == PTR_MAX) filled_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            filled_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            filled_q <= filled_d;
        end
    end

    // Contents need no reset: reads are masked to zero until the buffer has wrapped once.
    always_ff @(posedge clk) begin
        if (wr_en && !clr) mem_q[wr_ptr_q] <= {wr_i, wr_q};
    end

    assign old_i  = filled_q ? mem_q[wr_ptr_q][2*DATA_W-1:DATA_W] : '0;
    assign old_q  = filled_q ? mem_q[wr_ptr_q][DATA_W-1:0]        : '0;
    assign filled = filled_q;

endmodule

// File: rtl/iq_window_averager.sv
// Two-channel signed averager over 2^LOG2_LEN strobed samples, block or sliding window.
module iq_window_averager
    import iq_avg_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOG2_LEN = LOG2_LEN_DEF,
    parameter int ACC_W    = acc_w(DATA_W, LOG2_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              mode,
    input  logic              load_val,
    input  logic [DATA_W-1:0] i_in,
    input  logic [DATA_W-1:0] q_in,
    output logic [DATA_W-1:0] i_avg,
    output logic [DATA_W-1:0] q_avg,
    output logic              valid,
    output logic              bitclock
);

    localparam logic [LOG2_LEN-1:0] CNT_MAX = '1;

    logic                mode_q;
    logic [1:0]          state_q, state_d;
    logic [LOG2_LEN-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic [DATA_W-1:0]   avg_i_q, avg_i_d, avg_q_q, avg_q_d;
    logic                valid_q, valid_d;
    logic                bclk_q, bclk_d;

    logic                restart, take, wrap, slide_fire, dl_filled;
    logic [DATA_W-1:0]   old_i, old_q;
    logic [ACC_W-1:0]    sum_i, sum_q;

    // A change of mode restarts the window exactly like clr; the strobe in that cycle is dropped.
    assign restart = clr | (mode != mode_q);
    assign take    = load_val & ~restart;
    assign wrap    = take & (cnt_q == CNT_MAX);

    iq_delay_line #(
        .DATA_W   (DATA_W),
        .LOG2_LEN (LOG2_LEN)
    ) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (restart),
        .wr_en  (take & (mode_q == MODE_SLIDE)),
        .wr_i   (i_in),
        .wr_q   (q_in),
        .old_i  (old_i),
        .old_q  (old_q),
        .filled (dl_filled)
    );

    // In block mode the delay line is never written, so the oldest sample reads as zero.
    assign sum_i = acc_i_q + {{LOG2_LEN{i_in[DATA_W-1]}}, i_in}
                           - {{LOG2_LEN{old_i[DATA_W-1]}}, old_i};
    assign sum_q = acc_q_q + {{LOG2_LEN{q_in[DATA_W-1]}}, q_in}
                           - {{LOG2_LEN{old_q[DATA_W-1]}}, old_q};

    assign slide_fire = (state_q == ST_RUN) || wrap || dl_filled;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        avg_i_d = avg_i_q;
        avg_q_d = avg_q_q;
        valid_d = 1'b0;
        bclk_d  = bclk_q;
        if (restart) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            acc_i_d = '0;
            acc_q_d = '0;
        end else if (take) begin
            cnt_d = cnt_q + 1'b1;
            if (wrap) bclk_d = ~bclk_q;
            if (mode_q == MODE_BLOCK) begin
                state_d = ST_RUN;
                if (wrap) begin
                    avg_i_d = sum_i[ACC_W-1:LOG2_LEN];
                    avg_q_d = sum_q[ACC_W-1:LOG2_LEN];
                    valid_d = 1'b1;
                    acc_i_d = '0;
                    acc_q_d = '0;
                end else begin
                    acc_i_d = sum_i;
                    acc_q_d = sum_q;
                end
            end else begin
                acc_i_d = sum_i;
                acc_q_d = sum_q;
                state_d = slide_fire ? ST_RUN : ST_FILL;
                if (slide_fire) begin
                    avg_i_d = sum_i[ACC_W-1:LOG2_LEN];
                    avg_q_d = sum_q[ACC_W-1:LOG2_LEN];
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_BLOCK;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
            avg_i_q <= '0;
            avg_q_q <= '0;
            valid_q <= 1'b0;
            bclk_q  <= 1'b0;
        end else begin
            mode_q  <= mode;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            avg_i_q <= avg_i_d;
            avg_q_q <= avg_q_d;
            valid_q <= valid_d;
            bclk_q  <= bclk_d;
        end
    end

    assign i_avg    = avg_i_q;
    assign q_avg    = avg_q_q;
    assign valid    = valid_q;
    assign bitclock = bclk_q;

endmodule
